// File: rtl/relu_maxpool2x2_stream.sv
// Streaming ReLU + 2x2/stride-2 max-pool over a raster float32 pixel stream.
// Optional macro RELU_POOL_RELU_EN: clamp negatives to +0 before pooling; otherwise full IEEE max.
module relu_maxpool2x2_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 112,
    parameter int HEIGHT     = 112
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  frame_done
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
    localparam int IW = CW - 1;

    typedef enum logic {S_ROW_EVEN, S_ROW_ODD} state_t;

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [DATA_WIDTH-1:0] r_line_buf [WIDTH/2];
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid_out;
    logic                  r_frame_done;

    logic [DATA_WIDTH-1:0] w_smp, w_pair, w_lb, w_pool;
    logic [IW-1:0]         w_idx;
    logic                  w_col_last, w_row_last;

    // True when b is strictly greater than a; ties keep the earlier operand.
    function automatic logic gt(input logic [DATA_WIDTH-1:0] b, input logic [DATA_WIDTH-1:0] a);
`ifdef RELU_POOL_RELU_EN
        return b[DATA_WIDTH-2:0] > a[DATA_WIDTH-2:0];
`else
        if (a[DATA_WIDTH-2:0] == '0 && b[DATA_WIDTH-2:0] == '0) return 1'b0;
        if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1])                  return a[DATA_WIDTH-1];
        if (!a[DATA_WIDTH-1])                                    return b[DATA_WIDTH-2:0] > a[DATA_WIDTH-2:0];
        return b[DATA_WIDTH-2:0] < a[DATA_WIDTH-2:0];
`endif
    endfunction

    function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] first,
                                                   input logic [DATA_WIDTH-1:0] second);
        return gt(second, first) ? second : first;
    endfunction

`ifdef RELU_POOL_RELU_EN
    assign w_smp = data_in[DATA_WIDTH-1] ? '0 : data_in;
`else
    assign w_smp = data_in;
`endif

    assign w_idx      = r_col[CW-1:1];
    assign w_lb       = r_line_buf[w_idx];
    assign w_pair     = fmax(r_hold, w_smp);
    // Line buffer arrived a row earlier, so it is the first operand.
    assign w_pool     = fmax(w_lb, w_pair);
    assign w_col_last = (r_col == CW'(WIDTH - 1));
    assign w_row_last = (r_row == RW'(HEIGHT - 1));

    always_comb begin
        w_state_nxt = r_state;
        if (valid_in && w_col_last) begin
            if (w_row_last)                 w_state_nxt = S_ROW_EVEN;
            else if (r_state == S_ROW_EVEN) w_state_nxt = S_ROW_ODD;
            else                            w_state_nxt = S_ROW_EVEN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_ROW_EVEN;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_hold       <= '0;
            r_data_out   <= '0;
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
            if (valid_in) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
                if (!r_col[0]) begin
                    r_hold <= w_smp;
                end else if (r_state == S_ROW_ODD) begin
                    r_data_out   <= w_pool;
                    r_valid_out  <= 1'b1;
                    r_frame_done <= w_row_last && w_col_last;
                end
            end
        end
    end

    // Not cleared: every entry is written on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (!rst && valid_in && r_col[0] && r_state == S_ROW_EVEN)
            r_line_buf[w_idx] <= w_pair;
    end

    assign valid_out  = r_valid_out;
    assign data_out   = r_data_out;
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_relu_maxpool2x2_stream.sv
// Directed bench: 4x2 instance for hand-computed windows, default 112x112 instance for full frames.
module tb_relu_maxpool2x2_stream;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_vin = 1'b0, d_vin = 1'b0;
    logic [31:0] s_din = '0, d_din = '0;
    logic        s_vout, s_fd, d_vout, d_fd;
    logic [31:0] s_dout, d_dout;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] pxa [8];
    logic [31:0] d_q [$];
    int          d_fdcnt = 0;
    int          d_fd_orphan = 0;
    logic        d_fdlast = 1'b0;

    always #5 clk = ~clk;

    relu_maxpool2x2_stream #(.DATA_WIDTH(32), .WIDTH(4), .HEIGHT(2)) u_small (
        .clk(clk), .rst(rst), .valid_in(s_vin), .data_in(s_din),
        .valid_out(s_vout), .data_out(s_dout), .frame_done(s_fd));

    relu_maxpool2x2_stream u_dflt (
        .clk(clk), .rst(rst), .valid_in(d_vin), .data_in(d_din),
        .valid_out(d_vout), .data_out(d_dout), .frame_done(d_fd));

    always @(negedge clk) begin
        if (d_vout) begin
            d_q.push_back(d_dout);
            d_fdlast = d_fd;
        end
        if (d_fd) d_fdcnt++;
        if (d_fd && !d_vout) d_fd_orphan++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic s_idle();
        s_vin = 1'b0;
        @(negedge clk);
        chk("s_idle_vout", {31'b0, s_vout}, 32'd0);
    endtask

    // Streams pxa (row0 = 0..3, row1 = 4..7) and checks both strobes cycle-exactly.
    task automatic small_frame(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                               input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps && i > 0) s_idle();
            s_vin = 1'b1;
            s_din = pxa[i];
            @(negedge clk);
            if (i == 5) begin
                chk({tag, "_v0"},  {31'b0, s_vout}, 32'd1);
                chk({tag, "_d0"},  s_dout, e0);
                chk({tag, "_fd0"}, {31'b0, s_fd}, 32'd0);
            end else if (i == 6) begin
                chk({tag, "_gap_v"}, {31'b0, s_vout}, 32'd0);
                chk({tag, "_hold"},  s_dout, e0);
            end else if (i == 7) begin
                chk({tag, "_v1"},  {31'b0, s_vout}, 32'd1);
                chk({tag, "_d1"},  s_dout, e1);
                chk({tag, "_fd1"}, {31'b0, s_fd}, 32'd1);
            end
        end
        s_vin = 1'b0;
        @(negedge clk);
        chk({tag, "_after_v"}, {31'b0, s_vout}, 32'd0);
        chk({tag, "_after_d"}, s_dout, e1);
    endtask

    function automatic logic [31:0] dflt_exp(input int j);
        int idx;
        idx = (2 * (j / 56) + 1) * 112 + 2 * (j % 56) + 1;
        return 32'h3F80_0000 + idx;
    endfunction

    task automatic dflt_frame(input bit gaps);
        for (int k = 0; k < 112 * 112; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                d_vin = 1'b0;
                @(negedge clk);
            end
            d_vin = 1'b1;
            d_din = 32'h3F80_0000 + k;
            @(negedge clk);
        end
        d_vin = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic dflt_verify(input string tag);
        int bad;
        bad = 0;
        foreach (d_q[j]) if (d_q[j] !== dflt_exp(j)) bad++;
        chk({tag, "_count"},   d_q.size(), 3136);
        chk({tag, "_mism"},    bad, 0);
        chk({tag, "_fdcnt"},   d_fdcnt, 1);
        chk({tag, "_fdlast"},  {31'b0, d_fdlast}, 32'd1);
        chk({tag, "_orphan"},  d_fd_orphan, 0);
        d_q.delete();
        d_fdcnt = 0;
        d_fdlast = 1'b0;
    endtask

    initial begin
        logic [31:0] e_neg0, e_neg1, e_tie0;
`ifdef RELU_POOL_RELU_EN
        e_neg0 = 32'h0000_0000; e_neg1 = 32'h0000_0000; e_tie0 = 32'h0000_0000;
`else
        e_neg0 = 32'hBF80_0000; e_neg1 = 32'hBF00_0000; e_tie0 = 32'h8000_0000;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_s_vout", {31'b0, s_vout}, 32'd0);
        chk("rst_s_dout", s_dout, 32'd0);
        chk("rst_s_fd",   {31'b0, s_fd}, 32'd0);
        chk("rst_d_vout", {31'b0, d_vout}, 32'd0);
        chk("rst_d_dout", d_dout, 32'd0);

        // Positive frame: 4.0 from the left window, 3.0 from the right one.
        pxa = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h3F00_0000,
                32'h4080_0000, 32'hBF80_0000, 32'h3F00_0000, 32'h3E80_0000};
        small_frame("plan", 32'h4080_0000, 32'h4040_0000, 1'b0);

        // All -1.0 window and a -2,-0.5,-1,-3 window.
        pxa = '{32'hBF80_0000, 32'hBF80_0000, 32'hC000_0000, 32'hBF00_0000,
                32'hBF80_0000, 32'hBF80_0000, 32'hBF80_0000, 32'hC040_0000};
        small_frame("neg", e_neg0, e_neg1, 1'b0);

        // Signed-zero ties: earliest operand wins.
        pxa = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000,
                32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000};
        small_frame("tie", e_tie0, 32'h0000_0000, 1'b0);

        pxa = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h3F00_0000,
                32'h4080_0000, 32'hBF80_0000, 32'h3F00_0000, 32'h3E80_0000};
        small_frame("gaps", 32'h4080_0000, 32'h4040_0000, 1'b1);

        // Partial small frame, then reset with valid_in high while the strobe would be pending.
        for (int i = 0; i < 5; i++) begin
            s_vin = 1'b1;
            s_din = 32'h4100_0000;
            @(negedge clk);
        end
        rst = 1'b1;
        s_din = 32'h4200_0000;
        @(negedge clk);
        rst = 1'b0;
        s_vin = 1'b0;
        chk("srst_vout", {31'b0, s_vout}, 32'd0);
        chk("srst_dout", s_dout, 32'd0);
        small_frame("post_rst", 32'h4080_0000, 32'h4040_0000, 1'b0);

        d_q.delete();
        d_fdcnt = 0;
        dflt_frame(1'b0);
        dflt_verify("dflt");
        dflt_frame(1'b1);
        dflt_verify("dflt_gap");

        // 150 samples, the last one arriving together with rst (row 1, col 37).
        for (int k = 0; k < 149; k++) begin
            d_vin = 1'b1;
            d_din = 32'h4500_0000 + k;
            @(negedge clk);
        end
        rst = 1'b1;
        d_din = 32'h4600_0000;
        @(negedge clk);
        rst = 1'b0;
        d_vin = 1'b0;
        chk("drst_vout", {31'b0, d_vout}, 32'd0);
        chk("drst_dout", d_dout, 32'd0);
        d_q.delete();
        d_fdcnt = 0;
        d_fdlast = 1'b0;
        dflt_frame(1'b0);
        dflt_verify("dflt_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
